// File: rtl/fake_n64_joybus_sequencer.sv
// rtl/fake_n64_joybus_sequencer.sv - joybus transaction sequencer: command filter, turnaround, tx watchdog, recovery gap
// Owns the rx/tx direction of the line; one shared timer serves every timed state.
module fake_n64_joybus_sequencer #(
    parameter int TURNAROUND_CYCLES = 8,
    parameter int TX_TIMEOUT_CYCLES = 1024,
    parameter int RECOVER_CYCLES    = 16,
    parameter int CNT_WIDTH         = 11
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       rx_cmd_valid,
    input  logic [7:0] rx_cmd,
    input  logic       tx_done,
    output logic       cur_operation,
    output logic [7:0] cmd,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] unsupported_cnt,
    output logic [7:0] resp_cnt
);

    typedef enum logic [1:0] {
        LISTEN     = 2'd0,
        TURNAROUND = 2'd1,
        TRANSMIT   = 2'd2,
        RECOVER    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TURN_LOAD = CNT_WIDTH'(TURNAROUND_CYCLES);
    localparam logic [CNT_WIDTH-1:0] REC_LOAD  = CNT_WIDTH'(RECOVER_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TX_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] timer_q;
    logic                 cur_operation_q;
    logic [7:0]           cmd_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [7:0]           unsupported_cnt_q;
    logic [7:0]           resp_cnt_q;

    logic                 supported_d;
    logic [7:0]           unsupported_cnt_d;
    logic [7:0]           resp_cnt_d;

    // Only identify (00/FF) and poll (01) are served; other opcodes are counted and dropped.
    assign supported_d       = (rx_cmd == 8'h00) || (rx_cmd == 8'h01) || (rx_cmd == 8'hFF);
    assign unsupported_cnt_d = (unsupported_cnt_q == 8'hFF) ? 8'hFF : unsupported_cnt_q + 8'd1;
    assign resp_cnt_d        = resp_cnt_q + 8'd1;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q           <= LISTEN;
            timer_q           <= '0;
            cur_operation_q   <= 1'b0;
            cmd_q             <= 8'h00;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
            unsupported_cnt_q <= 8'h00;
            resp_cnt_q        <= 8'h00;
        end else begin
            case (state_q)
                LISTEN: begin
                    cur_operation_q <= 1'b0;
                    if (rx_cmd_valid) begin
                        if (supported_d) begin
                            cmd_q   <= rx_cmd;
                            timer_q <= TURN_LOAD;
                            state_q <= TURNAROUND;
                            busy_q  <= 1'b1;
                        end else begin
                            unsupported_cnt_q <= unsupported_cnt_d;
                        end
                    end
                end
                TURNAROUND: begin
                    if (timer_q == ONE) begin
                        timer_q         <= '0;
                        cur_operation_q <= 1'b1;
                        state_q         <= TRANSMIT;
                    end else begin
                        timer_q <= timer_q - ONE;
                    end
                end
                TRANSMIT: begin
                    // A completion landing on the timeout cycle counts as success.
                    if (tx_done) begin
                        resp_cnt_q      <= resp_cnt_d;
                        cur_operation_q <= 1'b0;
                        timer_q         <= REC_LOAD;
                        state_q         <= RECOVER;
                    end else if (timer_q == TO_LAST) begin
                        timeout_err_q   <= 1'b1;
                        cur_operation_q <= 1'b0;
                        timer_q         <= REC_LOAD;
                        state_q         <= RECOVER;
                    end else begin
                        timer_q <= timer_q + ONE;
                    end
                end
                RECOVER: begin
                    cur_operation_q <= 1'b0;
                    if (timer_q == ONE) begin
                        timer_q <= '0;
                        state_q <= LISTEN;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - ONE;
                    end
                end
                default: begin
                    state_q <= LISTEN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cur_operation   = cur_operation_q;
    assign cmd             = cmd_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
    assign unsupported_cnt = unsupported_cnt_q;
    assign resp_cnt        = resp_cnt_q;

endmodule
